// File: rtl/piso_tx.sv
// piso_tx: parallel-in / serial-out transmitter, MSB first.
//
// A word offered on data_in is taken when load_valid && load_ready at a
// rising clk edge, then shifted out one bit per cycle on so with so_valid
// high.  done pulses on the last frame bit, which is also the one cycle
// (besides IDLE) where load_ready is high, so back-to-back words stream
// with no gap.
//
// Optional feature: define PISO_TX_PARITY_EN to append one even-parity
// bit (XOR of the captured word) after data_in[0]; done and load_ready
// then move to that parity cycle.  Default build has no parity logic.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   load_valid parallel word offered on data_in
//   load_ready block accepts a word this cycle (registered, 1 in reset)
//   data_in    WIDTH-bit parallel word, sampled only on accept
//   so         serial data out (registered)
//   so_valid   so carries a frame bit (registered)
//   busy       frame in progress (registered)
//   done       one-cycle pulse on the last frame bit (registered)

module piso_tx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t           state;
    // Holds the bits still to be sent, next one at the top.
    logic [WIDTH-1:0] shreg;
    // Bits remaining in the frame including the one currently on so.
    logic [CW-1:0]    cnt;
`ifdef PISO_TX_PARITY_EN
    logic             par;
`endif
    logic             accept;

    assign accept = load_valid && load_ready;

    // Frame sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            so         <= 1'b0;
            so_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
`ifdef PISO_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else if (accept) begin
            // MSB goes straight to so; the rest waits in shreg.
            state      <= SHIFT;
            shreg      <= {data_in[WIDTH-2:0], 1'b0};
            cnt        <= CW'(WIDTH);
            so         <= data_in[WIDTH-1];
            so_valid   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            load_ready <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par        <= ^data_in;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                    if (cnt == CW'(1)) begin
`ifdef PISO_TX_PARITY_EN
                        // Data done; one extra cycle carries the parity bit.
                        state      <= PARITY;
                        so         <= par;
                        so_valid   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b1;
                        load_ready <= 1'b1;
`else
                        state      <= IDLE;
                        so         <= 1'b0;
                        so_valid   <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                        load_ready <= 1'b1;
`endif
                    end else begin
                        shreg    <= {shreg[WIDTH-2:0], 1'b0};
                        so       <= shreg[WIDTH-1];
                        so_valid <= 1'b1;
                        busy     <= 1'b1;
`ifdef PISO_TX_PARITY_EN
                        done       <= 1'b0;
                        load_ready <= 1'b0;
`else
                        // Next cycle carries data_in[0], the last frame bit.
                        done       <= (cnt == CW'(2));
                        load_ready <= (cnt == CW'(2));
`endif
                    end
                end
`ifdef PISO_TX_PARITY_EN
                PARITY: begin
                    state      <= IDLE;
                    so         <= 1'b0;
                    so_valid   <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                end
`endif
                default: begin
                    state      <= IDLE;
                    so         <= 1'b0;
                    so_valid   <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: bench for piso_tx (WIDTH=4).  A queue of expected frame bits
// predicts the outputs every cycle; directed frames carry literal
// expectations; a serial-in loopback register checks each word at done.
// Honours PISO_TX_PARITY_EN the same way as the design.

module tb_piso_tx;

    localparam int unsigned W = 4;
`ifdef PISO_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = int'(W) + (PAR ? 1 : 0);

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] data_in;
    logic         so;
    logic         so_valid;
    logic         busy;
    logic         done;

    piso_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_in    (data_in),
        .so         (so),
        .so_valid   (so_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: queue of bits still to appear on so, one popped per cycle.
    bit           mq[$];
    logic [W-1:0] wq[$];
    int           n_acc = 0;

    always @(posedge clk or posedge rst) begin
        bit acc;
        bit p;
        if (rst) begin
            mq.delete();
            wq.delete();
        end else begin
            acc = load_valid && (mq.size() <= 1);
            if (mq.size() > 0) void'(mq.pop_front());
            if (acc) begin
                p = 1'b0;
                for (int i = int'(W) - 1; i >= 0; i--) begin
                    mq.push_back(data_in[i]);
                    p = p ^ data_in[i];
                end
                if (PAR) mq.push_back(p);
                wq.push_back(data_in);
                n_acc++;
            end
        end
    end

    // Per-cycle compare against the model plus serial loopback check.
    logic [W-1:0] lb = '0;
    int           lb_idx = 0;

    always @(negedge clk) begin
        bit ev;
        ev = (mq.size() > 0);
        chk("so",         32'(so),         ev ? 32'(mq[0]) : 32'(0));
        chk("so_valid",   32'(so_valid),   32'(ev));
        chk("busy",       32'(busy),       32'(ev));
        chk("done",       32'(done),       32'(mq.size() == 1));
        chk("load_ready", 32'(load_ready), 32'(mq.size() <= 1));
        if (rst) begin
            lb_idx = 0;
        end else if (so_valid) begin
            if (lb_idx < int'(W)) lb = {lb[W-2:0], so};
            lb_idx++;
            if (done) begin
                lb_idx = 0;
                if (wq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL loopback: done with no word outstanding at %0t", $time);
                end else begin
                    chk("loopback", 32'(lb), 32'(wq.pop_front()));
                end
            end
        end
    end

    // Send a, optionally hold load_valid with b; check nbits literal bits
    // (MSB-first in ev) then the idle cycle after.
    task automatic send(input string nm, input logic [W-1:0] a, input bit hold,
                        input logic [W-1:0] b, input logic [15:0] ev, input int nbits);
        @(posedge clk); #1;
        load_valid = 1'b1;
        data_in    = a;
        @(posedge clk); #1;
        if (hold) data_in = b;
        else      load_valid = 1'b0;
        for (int k = 1; k <= nbits; k++) begin
            @(negedge clk);
            chk({nm, "_so"},  32'(so),         32'(ev[16-k]));
            chk({nm, "_vld"}, 32'(so_valid),   32'(1));
            chk({nm, "_done"},32'(done),       32'((k % NB) == 0));
            chk({nm, "_rdy"}, 32'(load_ready), 32'((k % NB) == 0));
            @(posedge clk); #1;
            if (hold && k == NB) load_valid = 1'b0;
        end
        @(negedge clk);
        chk({nm, "_idle_busy"}, 32'(busy),       32'(0));
        chk({nm, "_idle_vld"},  32'(so_valid),   32'(0));
        chk({nm, "_idle_rdy"},  32'(load_ready), 32'(1));
    endtask

    logic [15:0] e1011, eA5, eC3, e1001, e0001;
    int start, cyc;

    initial begin
`ifdef PISO_TX_PARITY_EN
        e1011 = 16'b10111_00000000000;
        eA5   = 16'b1010001010_000000;
        eC3   = 16'b1100000110_000000;
        e1001 = 16'b10010_00000000000;
        e0001 = 16'b00011_00000000000;
`else
        e1011 = 16'b1011_000000000000;
        eA5   = 16'b10100101_00000000;
        eC3   = 16'b11000011_00000000;
        e1001 = 16'b1001_000000000000;
        e0001 = 16'b0001_000000000000;
`endif
        rst        = 1'b0;
        load_valid = 1'b0;
        data_in    = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_so",    32'(so),         32'(0));
        chk("rst_vld",   32'(so_valid),   32'(0));
        chk("rst_busy",  32'(busy),       32'(0));
        chk("rst_done",  32'(done),       32'(0));
        chk("rst_rdy",   32'(load_ready), 32'(1));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send("f1011", 4'b1011, 1'b0, 4'h0, e1011, NB);
        send("fA5",   4'hA,    1'b1, 4'h5, eA5,   2 * NB);
        send("fC3",   4'hC,    1'b1, 4'h3, eC3,   2 * NB);
        send("f1001", 4'b1001, 1'b0, 4'h0, e1001, NB);

        // Reset mid-frame aborts immediately.
        @(posedge clk); #1;
        load_valid = 1'b1;
        data_in    = 4'hF;
        @(posedge clk); #1;
        load_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("abort_so",   32'(so),         32'(0));
        chk("abort_vld",  32'(so_valid),   32'(0));
        chk("abort_busy", 32'(busy),       32'(0));
        chk("abort_done", 32'(done),       32'(0));
        chk("abort_rdy",  32'(load_ready), 32'(1));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send("f0001", 4'h1, 1'b0, 4'h0, e0001, NB);

        // Random streaming; model and loopback check every word.
        start = n_acc;
        cyc   = 0;
        while (n_acc < start + 200 && cyc < 5000) begin
            @(posedge clk); #1;
            load_valid = ($urandom_range(0, 3) != 0);
            data_in    = W'($urandom);
            cyc++;
        end
        load_valid = 1'b0;
        if (cyc >= 5000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rand_budget: accepted %0d words, required 200", n_acc - start);
        end
        repeat (2 * NB + 2) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
